// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: producer handshakes and register-file write port of the write queue
interface regfile_write_queue_if #(parameter int DEPTH = 4);
  logic a_valid;
  logic [4:0] a_reg;
  logic [31:0] a_data;
  logic a_ready;
  logic b_valid;
  logic [4:0] b_reg;
  logic [31:0] b_data;
  logic b_ready;
  logic write_enable;
  logic [4:0] write_reg_rd;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input a_ready, b_ready, write_enable, write_reg_rd, write_data, pending_mask, count
  );
  modport slave (
    input a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, write_enable, write_reg_rd, write_data, pending_mask, count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order dual-producer FIFO feeding the register file write port
module regfile_write_queue #(parameter int DEPTH = 4) (
  input logic clk,
  input logic reset,
  input logic clk_enable,
  regfile_write_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0] regs [DEPTH];
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] head, tail, tail_b;
  logic [CW-1:0] cnt, free;
  logic en, pop, enq_a, enq_b;
  logic [31:0] mask;
  assign en = clk_enable & reset;
  assign pop = en & (cnt != '0);
  assign free = CW'(DEPTH) - cnt + CW'(pop);
  assign bus.a_ready = en & (free >= CW'(1));
  assign bus.b_ready = en & (free >= CW'(2));
  // $0 handshakes complete but never occupy a slot
  assign enq_a = bus.a_valid & bus.a_ready & (bus.a_reg != 5'd0);
  assign enq_b = bus.b_valid & bus.b_ready & (bus.b_reg != 5'd0);
  assign tail_b = tail + AW'(enq_a);
  assign bus.write_enable = pop;
  assign bus.write_reg_rd = pop ? regs[head] : '0;
  assign bus.write_data = pop ? mem[head] : '0;
  assign bus.pending_mask = reset ? mask : '0;
  assign bus.count = reset ? cnt : '0;
  // an entry is occupied when its distance from head is below the count
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(AW'(AW'(i) - head)) < cnt) mask = mask | (32'd1 << regs[AW'(i)]);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (enq_a) begin
        regs[tail] <= bus.a_reg;
        mem[tail] <= bus.a_data;
      end
      if (enq_b) begin
        regs[tail_b] <= bus.b_reg;
        mem[tail_b] <= bus.b_data;
      end
      tail <= tail_b + AW'(enq_b);
      head <= head + AW'(pop);
      cnt <= cnt + CW'(enq_a) + CW'(enq_b) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed per-cycle vectors for the register file write queue
module tb_regfile_write_queue;
  typedef struct {
    logic rst, ce, av;
    logic [4:0] ar;
    logic [31:0] ad;
    logic bv;
    logic [4:0] br;
    logic [31:0] bd;
    logic we;
    logic [4:0] wr;
    logic [31:0] wd;
    logic [31:0] pm;
    logic [2:0] cnt;
    logic ard, brd;
  } vec_t;
  logic clk = 1'b1;
  logic reset, clk_enable;
  int compared = 0;
  int mismatched = 0;
  vec_t v[$];
  regfile_write_queue_if #(.DEPTH(4)) bus();
  regfile_write_queue #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // inputs are applied just after a rising edge; outputs are checked on the falling edge
  task automatic cycle(input vec_t t, input string tag);
    reset = t.rst;
    clk_enable = t.ce;
    bus.a_valid = t.av;
    bus.a_reg = t.ar;
    bus.a_data = t.ad;
    bus.b_valid = t.bv;
    bus.b_reg = t.br;
    bus.b_data = t.bd;
    @(negedge clk);
    chk({tag, " write_enable"}, 32'(bus.write_enable), 32'(t.we));
    chk({tag, " write_reg_rd"}, 32'(bus.write_reg_rd), 32'(t.wr));
    chk({tag, " write_data"}, bus.write_data, t.wd);
    chk({tag, " pending_mask"}, bus.pending_mask, t.pm);
    chk({tag, " count"}, 32'(bus.count), 32'(t.cnt));
    chk({tag, " a_ready"}, 32'(bus.a_ready), 32'(t.ard));
    chk({tag, " b_ready"}, 32'(bus.b_ready), 32'(t.brd));
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset held with both valids high
    v.push_back(vec_t'{0,1, 1,5'd1,32'h1, 1,5'd2,32'h2, 0,5'd0,32'h0,32'h0,3'd0,0,0});
    v.push_back(vec_t'{0,1, 1,5'd1,32'h1, 1,5'd2,32'h2, 0,5'd0,32'h0,32'h0,3'd0,0,0});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    // single write, one cycle latency
    v.push_back(vec_t'{1,1, 1,5'd5,32'hDEADBEEF, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd5,32'hDEADBEEF,32'h20,3'd1,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    // dual push to the same register: A then B
    v.push_back(vec_t'{1,1, 1,5'd3,32'h11, 1,5'd3,32'h22, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd3,32'h11,32'h8,3'd2,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd3,32'h22,32'h8,3'd1,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    // $0 push is accepted and dropped
    v.push_back(vec_t'{1,1, 1,5'd0,32'h99, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    // fill with dual pushes starting at head=tail=3, crossing the wrap
    v.push_back(vec_t'{1,1, 1,5'd1,32'hA1, 1,5'd2,32'hB2, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    v.push_back(vec_t'{1,1, 1,5'd4,32'hA4, 1,5'd6,32'hB6, 1,5'd1,32'hA1,32'h6,3'd2,1,1});
    v.push_back(vec_t'{1,1, 1,5'd7,32'hA7, 1,5'd8,32'hB8, 1,5'd2,32'hB2,32'h54,3'd3,1,1});
    v.push_back(vec_t'{1,1, 1,5'd9,32'hA9, 1,5'd10,32'hBA, 1,5'd4,32'hA4,32'h1D0,3'd4,1,0});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd6,32'hB6,32'h3C0,3'd4,1,0});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd7,32'hA7,32'h380,3'd3,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd8,32'hB8,32'h300,3'd2,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd9,32'hA9,32'h200,3'd1,1,1});
    v.push_back(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1});
    for (int i = 0; i < v.size(); i++) cycle(v[i], $sformatf("vec%0d", i));
    // queue three entries: [12,13,14] after one pop
    cycle(vec_t'{1,1, 1,5'd11,32'hC1, 1,5'd12,32'hC2, 0,5'd0,32'h0,32'h0,3'd0,1,1}, "stall_q0");
    cycle(vec_t'{1,1, 1,5'd13,32'hC3, 1,5'd14,32'hC4, 1,5'd11,32'hC1,32'h1800,3'd2,1,1}, "stall_q1");
    // four stalled cycles with valids offered: nothing moves
    for (int i = 0; i < 4; i++)
      cycle(vec_t'{1,0, 1,5'd15,32'hFF, 1,5'd16,32'hEE, 0,5'd0,32'h0,32'h7000,3'd3,0,0}, $sformatf("stall%0d", i));
    cycle(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 1,5'd12,32'hC2,32'h7000,3'd3,1,1}, "resume");
    // reset mid-drain discards the remaining two entries
    cycle(vec_t'{0,1, 1,5'd17,32'h77, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,0,0}, "mid_rst");
    cycle(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1}, "post_rst0");
    cycle(vec_t'{1,1, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0,32'h0,3'd0,1,1}, "post_rst1");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
